// File: rtl/sync_pkg.sv
// Shared types and constants for the synchronisation-link receive framer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sync_pkg;

  // Framer states, in frame order
  typedef enum logic [3:0] {
    SYNC_IDLE  = 4'd0,
    SYNC_HDR   = 4'd1,
    SYNC_LEN_H = 4'd2,
    SYNC_LEN_L = 4'd3,
    SYNC_DATA  = 4'd4,
    SYNC_CRC_H = 4'd5,
    SYNC_CRC_L = 4'd6,
    SYNC_CHECK = 4'd7,
    SYNC_HOLD  = 4'd8
  } sync_state_e;

  // Buffer status codes presented on sync_Btoa_en
  localparam logic [1:0] SYNC_ST_IDLE = 2'b00;
  localparam logic [1:0] SYNC_ST_OK   = 2'b10;
  localparam logic [1:0] SYNC_ST_ERR  = 2'b01;

  // Receive buffer size in bytes; also the largest legal LEN
  localparam int SYNC_BUF_DEPTH = 2048;

  // CRC-16/CCITT, MSB first, no reflection
  localparam logic [15:0] SYNC_CRC_POLY = 16'h1021;
  localparam logic [15:0] SYNC_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/sync_rx_pack_if.sv
// Byte stream in, receive-buffer write port and frame status out.
// Latency: n/a (wiring only).
// Backpressure: none; the byte source may present a byte every clock.
interface sync_rx_pack_if;

  logic [7:0]  rx_byte;
  logic        rx_byte_vld;
  logic        slink_buf_wen;
  logic [10:0] slink_buf_waddr;
  logic [7:0]  slink_buf_wdata;
  logic        sync_recv_en;
  logic [1:0]  sync_Btoa_en;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  // Byte source / status consumer side
  modport master (
    output rx_byte, rx_byte_vld,
    input  slink_buf_wen, slink_buf_waddr, slink_buf_wdata,
    input  sync_recv_en, sync_Btoa_en, frame_ok_cnt, frame_err_cnt
  );

  // Framer side
  modport slave (
    input  rx_byte, rx_byte_vld,
    output slink_buf_wen, slink_buf_waddr, slink_buf_wdata,
    output sync_recv_en, sync_Btoa_en, frame_ok_cnt, frame_err_cnt
  );

endinterface

// File: rtl/crc16_ccitt_byte.sv
// One-byte CRC-16/CCITT step (poly 0x1021, MSB first, no reflection).
// Latency: combinational, zero clocks.
// Backpressure: none; pure function of its inputs.
module crc16_ccitt_byte
  import sync_pkg::*;
(
  input  logic [7:0]  data_in,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;
  logic        fb;

  // Shift the byte in MSB first, folding the polynomial on each feedback bit
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data_in[i];
      c  = {c[14:0], 1'b0};
      if (fb) begin
        c = c ^ SYNC_CRC_POLY;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/sync_rx_pack.sv
// Sync-link receive framer: hunts HDR0/HDR1, writes payload to the 2048-byte buffer, flags good/bad frames.
// Latency: buffer write 1 clock after the byte; sync_recv_en/status 2 clocks after CRC_L is sampled.
// Backpressure: none; a byte may arrive every clock, bytes seen during HOLD are dropped. CRC checking needs SYNC_RX_CRC_EN.
module sync_rx_pack
  import sync_pkg::*;
#(
  parameter logic [7:0]  HDR0        = 8'hEB,
  parameter logic [7:0]  HDR1        = 8'h90,
  parameter logic [15:0] GAP_MAX     = 16'd1000,
  parameter logic [11:0] HOLD_CYCLES = 12'd2100
) (
  input logic           clk,
  input logic           reset,
  sync_rx_pack_if.slave bus
);

  localparam logic [3:0] ST_IDLE  = SYNC_IDLE;
  localparam logic [3:0] ST_HDR   = SYNC_HDR;
  localparam logic [3:0] ST_LEN_H = SYNC_LEN_H;
  localparam logic [3:0] ST_LEN_L = SYNC_LEN_L;
  localparam logic [3:0] ST_DATA  = SYNC_DATA;
  localparam logic [3:0] ST_CRC_H = SYNC_CRC_H;
  localparam logic [3:0] ST_CRC_L = SYNC_CRC_L;
  localparam logic [3:0] ST_CHECK = SYNC_CHECK;
  localparam logic [3:0] ST_HOLD  = SYNC_HOLD;

  logic [3:0]  state_q, state_d;
  logic [7:0]  len_h_q;
  logic [11:0] len_q;
  logic [11:0] data_cnt_q;
  logic [15:0] gap_q;
  logic [11:0] hold_cnt_q;
  logic        hdr0_seen_q;

  logic        wen_q;
  logic [10:0] waddr_q;
  logic [7:0]  wdata_q;
  logic        recv_q;
  logic [1:0]  status_q;
  logic [15:0] ok_cnt_q;
  logic [15:0] err_cnt_q;

  logic        vld;
  logic [7:0]  din;
  logic [15:0] len_word;
  logic        len_bad;
  logic        in_frame;
  logic        gap_expire;
  logic        hdr_accept;
  logic        len_err;
  logic        last_byte;
  logic        hold_done;
  logic        hold_pair;
  logic        crc_ok;
  logic        good_ev;
  logic        bad_ev;

  assign vld = bus.rx_byte_vld;
  assign din = bus.rx_byte;

  // Frame-level events decoded from the current state and incoming byte
  always_comb begin
    len_word   = {len_h_q, din};
    len_bad    = (len_word == 16'd0) || (len_word > 16'(SYNC_BUF_DEPTH));
    in_frame   = state_q inside {ST_LEN_H, ST_LEN_L, ST_DATA, ST_CRC_H, ST_CRC_L};
    gap_expire = in_frame && !vld && (gap_q >= GAP_MAX);
    hdr_accept = (state_q == ST_HDR) && vld && (din == HDR1);
    len_err    = (state_q == ST_LEN_L) && vld && len_bad;
    last_byte  = (state_q == ST_DATA) && vld && (data_cnt_q == len_q - 12'd1);
    hold_done  = (state_q == ST_HOLD) && (hold_cnt_q == HOLD_CYCLES - 12'd1);
    // A new header arriving while downstream still reads the buffer is a lost frame
    hold_pair  = (state_q == ST_HOLD) && vld && hdr0_seen_q && (din == HDR1);
    good_ev    = (state_q == ST_CHECK) && crc_ok;
    bad_ev     = ((state_q == ST_CHECK) && !crc_ok) || len_err || gap_expire;
  end

  // Next-state decode; an expired inter-byte gap overrides everything in-frame
  always_comb begin
    state_d = state_q;
    if (gap_expire) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (vld && din == HDR0) state_d = ST_HDR;
        ST_HDR:   if (vld) state_d = (din == HDR1) ? ST_LEN_H :
                                     (din == HDR0) ? ST_HDR   : ST_IDLE;
        ST_LEN_H: if (vld) state_d = ST_LEN_L;
        ST_LEN_L: if (vld) state_d = len_bad ? ST_IDLE : ST_DATA;
        ST_DATA:  if (last_byte) state_d = ST_CRC_H;
        ST_CRC_H: if (vld) state_d = ST_CRC_L;
        ST_CRC_L: if (vld) state_d = ST_CHECK;
        ST_CHECK: state_d = crc_ok ? ST_HOLD : ST_IDLE;
        ST_HOLD:  if (hold_done) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register and per-frame bookkeeping (length, byte index, gap and hold timers)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_h_q     <= 8'd0;
      len_q       <= 12'd0;
      data_cnt_q  <= 12'd0;
      gap_q       <= 16'd0;
      hold_cnt_q  <= 12'd0;
      hdr0_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LEN_H && vld) len_h_q <= din;
      if (state_q == ST_LEN_L && vld && !len_bad) begin
        len_q      <= len_word[11:0];
        data_cnt_q <= 12'd0;
      end
      if (state_q == ST_DATA && vld) data_cnt_q <= data_cnt_q + 12'd1;
      gap_q      <= (in_frame && !vld) ? gap_q + 16'd1 : 16'd0;
      hold_cnt_q <= (state_q == ST_HOLD) ? hold_cnt_q + 12'd1 : 12'd0;
      if (state_q != ST_HOLD) hdr0_seen_q <= 1'b0;
      else if (vld)           hdr0_seen_q <= (din == HDR0);
    end
  end

  // Buffer write port: one registered strobe per payload byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wen_q   <= 1'b0;
      waddr_q <= 11'd0;
      wdata_q <= 8'd0;
    end else begin
      wen_q <= (state_q == ST_DATA) && vld;
      if (state_q == ST_DATA && vld) begin
        waddr_q <= data_cnt_q[10:0];
        wdata_q <= din;
      end
    end
  end

  // Status, frame-ready level and wrapping frame counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q  <= SYNC_ST_IDLE;
      recv_q    <= 1'b0;
      ok_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      if (hdr_accept)  status_q <= SYNC_ST_IDLE;
      else if (good_ev) status_q <= SYNC_ST_OK;
      else if (bad_ev)  status_q <= SYNC_ST_ERR;
      if (good_ev)        recv_q <= 1'b1;
      else if (hold_done) recv_q <= 1'b0;
      if (good_ev) ok_cnt_q <= ok_cnt_q + 16'd1;
      if (bad_ev || hold_pair) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

`ifdef SYNC_RX_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_next;
  logic [15:0] rx_crc_q;

  crc16_ccitt_byte u_crc (
    .data_in (din),
    .crc_in  (crc_q),
    .crc_out (crc_next)
  );

  // Running CRC over LEN_H..last payload byte, plus the received trailer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q    <= SYNC_CRC_INIT;
      rx_crc_q <= 16'd0;
    end else begin
      if (hdr_accept) begin
        crc_q <= SYNC_CRC_INIT;
      end else if (vld && (state_q inside {ST_LEN_H, ST_LEN_L, ST_DATA})) begin
        crc_q <= crc_next;
      end
      if (vld && state_q == ST_CRC_H) rx_crc_q[15:8] <= din;
      if (vld && state_q == ST_CRC_L) rx_crc_q[7:0]  <= din;
    end
  end

  assign crc_ok = (rx_crc_q == crc_q);
`else
  // Trailer bytes are consumed by the FSM but not checked
  assign crc_ok = 1'b1;
`endif

  assign bus.slink_buf_wen   = wen_q;
  assign bus.slink_buf_waddr = waddr_q;
  assign bus.slink_buf_wdata = wdata_q;
  assign bus.sync_recv_en    = recv_q;
  assign bus.sync_Btoa_en    = status_q;
  assign bus.frame_ok_cnt    = ok_cnt_q;
  assign bus.frame_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sync_rx_pack.sv
`timescale 1ns/1ps
module tb_sync_rx_pack;
  import sync_pkg::*;

  localparam logic [7:0]  HDR0        = 8'hEB;
  localparam logic [7:0]  HDR1        = 8'h90;
  localparam logic [15:0] GAP_MAX     = 16'd1000;
  localparam logic [11:0] HOLD_CYCLES = 12'd2100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  sync_rx_pack_if bus();

  sync_rx_pack #(
    .HDR0(HDR0), .HDR1(HDR1), .GAP_MAX(GAP_MAX), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic        is_ok;
    int          cyc;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  status;
  } ev_t;

  wr_t exp_wr_q[$];
  ev_t exp_ev_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // reference model state
  logic [15:0] m_ok = 16'd0;
  logic [15:0] m_err = 16'd0;
  logic [1:0]  m_status = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC-16/CCITT reference, byte-at-a-time form
  function automatic logic [15:0] crc_ref(input logic [7:0] msg[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (msg[i]) begin
      c = c ^ {msg[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] prev_ok = 16'd0;
  logic [15:0] prev_err = 16'd0;
  logic        prev_recv = 1'b0;
  int          high_len = 0;
  wr_t         mon_w;
  ev_t         mon_e;

  task automatic pop_event(input logic is_ok);
    if (exp_ev_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: ok=%0d ok_cnt=%0d err_cnt=%0d, none expected", is_ok,
               bus.frame_ok_cnt, bus.frame_err_cnt);
    end else begin
      mon_e = exp_ev_q.pop_front();
      check("event_kind", 32'(is_ok), 32'(mon_e.is_ok));
      if (is_ok) check("recv_rise_cycle", cyc, mon_e.cyc);
      check("ok_cnt", 32'(bus.frame_ok_cnt), 32'(mon_e.ok_cnt));
      check("err_cnt", 32'(bus.frame_err_cnt), 32'(mon_e.err_cnt));
      check("status", 32'(bus.sync_Btoa_en), 32'(mon_e.status));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_ok = 16'd0;
      prev_err = 16'd0;
      prev_recv = 1'b0;
      high_len = 0;
    end else begin
      if (bus.slink_buf_wen) begin
        if (exp_wr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data %02h, none expected", bus.slink_buf_waddr,
                   bus.slink_buf_wdata);
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("wr_addr", 32'(bus.slink_buf_waddr), 32'(mon_w.addr));
          check("wr_data", 32'(bus.slink_buf_wdata), 32'(mon_w.data));
        end
      end
      if (bus.sync_recv_en && !prev_recv) pop_event(1'b1);
      if (bus.frame_err_cnt != prev_err) pop_event(1'b0);
      if (bus.sync_recv_en) high_len++;
      if (!bus.sync_recv_en && prev_recv) begin
        check("recv_high_len", high_len, 32'(HOLD_CYCLES));
        high_len = 0;
      end
      prev_ok = bus.frame_ok_cnt;
      prev_err = bus.frame_err_cnt;
      prev_recv = bus.sync_recv_en;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte = b;
    bus.rx_byte_vld = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_byte = 8'h00;
      bus.rx_byte_vld = 1'b0;
    end
  endtask

  task automatic rand_gap(input int max_gap);
    if (max_gap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, max_gap));
  endtask

  task automatic push_ev(input logic is_ok, input int at_cyc);
    ev_t e;
    e.is_ok = is_ok;
    e.cyc = at_cyc;
    e.ok_cnt = m_ok;
    e.err_cnt = m_err;
    e.status = m_status;
    exp_ev_q.push_back(e);
  endtask

  // Sends one frame and records the expected writes and frame outcome.
  task automatic run_frame(input logic [7:0] pl[$], input int len_field, input bit flip_crc,
                           input bit in_hold, input int max_gap, input int mid_stall,
                           input bit wait_hold);
    logic [7:0]  src[$];
    logic [15:0] crc;
    logic [15:0] lf;
    wr_t         w;
    bit          legal;
    bit          good;
    int          crcl_cyc;
    lf = 16'(len_field);
    legal = (len_field >= 1) && (len_field <= SYNC_BUF_DEPTH);
    drive(HDR0);
    drive(HDR1);
    if (in_hold) begin
      m_err = m_err + 16'd1;
      push_ev(1'b0, 0);
    end else begin
      m_status = SYNC_ST_IDLE;
      if (max_gap > 0) begin
        idle(1);
        check("status_clear_on_hdr", 32'(bus.sync_Btoa_en), 32'(SYNC_ST_IDLE));
      end
    end
    src.push_back(lf[15:8]);
    src.push_back(lf[7:0]);
    drive(lf[15:8]);
    rand_gap(max_gap);
    drive(lf[7:0]);
    if (!legal) begin
      if (!in_hold) begin
        m_err = m_err + 16'd1;
        m_status = SYNC_ST_ERR;
        push_ev(1'b0, 0);
      end
      idle(3);
      return;
    end
    foreach (pl[i]) begin
      rand_gap(max_gap);
      if (mid_stall > 0 && i == pl.size() / 2) idle(mid_stall);
      drive(pl[i]);
      src.push_back(pl[i]);
      if (!in_hold) begin
        w.addr = 11'(i);
        w.data = pl[i];
        exp_wr_q.push_back(w);
      end
    end
    crc = crc_ref(src);
    if (flip_crc) crc[0] = ~crc[0];
    rand_gap(max_gap);
    drive(crc[15:8]);
    rand_gap(max_gap);
    drive(crc[7:0]);
    crcl_cyc = cyc;
    good = 1'b0;
    if (!in_hold) begin
`ifdef SYNC_RX_CRC_EN
      good = !flip_crc;
`else
      good = 1'b1;
`endif
      if (good) begin
        m_ok = m_ok + 16'd1;
        m_status = SYNC_ST_OK;
        push_ev(1'b1, crcl_cyc + 2);
      end else begin
        m_err = m_err + 16'd1;
        m_status = SYNC_ST_ERR;
        push_ev(1'b0, 0);
      end
    end
    if (good && wait_hold) idle(int'(HOLD_CYCLES) + 4);
    else idle(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pl[$];
    logic [7:0] pl2[$];
    wr_t w;
    int  len;
    int  lf;
    bus.rx_byte = 8'h00;
    bus.rx_byte_vld = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wen", 32'(bus.slink_buf_wen), 0);
    check("rst_waddr", 32'(bus.slink_buf_waddr), 0);
    check("rst_wdata", 32'(bus.slink_buf_wdata), 0);
    check("rst_recv", 32'(bus.sync_recv_en), 0);
    check("rst_status", 32'(bus.sync_Btoa_en), 0);
    check("rst_ok_cnt", 32'(bus.frame_ok_cnt), 0);
    check("rst_err_cnt", 32'(bus.frame_err_cnt), 0);
    reset = 1'b1;
    idle(2);

    // good LEN=4 frame, back-to-back bytes
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(pl, 4, 1'b0, 1'b0, 0, 0, 1'b1);
    // same frame with the low CRC byte corrupted
    run_frame(pl, 4, 1'b1, 1'b0, 0, 0, 1'b1);

    // largest legal frame, then the first illegal length, then zero length
    pl.delete();
    for (int i = 0; i < SYNC_BUF_DEPTH; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_frame(pl, SYNC_BUF_DEPTH, 1'b0, 1'b0, 0, 0, 1'b1);
    pl.delete();
    run_frame(pl, SYNC_BUF_DEPTH + 1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_frame(pl, 0, 1'b0, 1'b0, 0, 0, 1'b1);

    // repeated HDR0 before HDR1: EB EB 90 00 01 55 crc
    drive(HDR0);
    pl = '{8'h55};
    run_frame(pl, 1, 1'b0, 1'b0, 0, 0, 1'b1);

    // second frame arriving while the first is held
    pl = '{8'h01, 8'h02, 8'h03};
    run_frame(pl, 3, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(3);
    pl2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frame(pl2, 5, 1'b0, 1'b1, 0, 0, 1'b0);
    idle(int'(HOLD_CYCLES));

    // exactly GAP_MAX idle clocks mid-payload is still a good frame
    pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    run_frame(pl, 6, 1'b0, 1'b0, 0, int'(GAP_MAX), 1'b1);

    // GAP_MAX+1 idle clocks mid-payload aborts the frame
    drive(HDR0);
    drive(HDR1);
    m_status = SYNC_ST_IDLE;
    drive(8'h00);
    drive(8'h08);
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'hC0 + i));
      w.addr = 11'(i);
      w.data = 8'(8'hC0 + i);
      exp_wr_q.push_back(w);
    end
    m_err = m_err + 16'd1;
    m_status = SYNC_ST_ERR;
    push_ev(1'b0, 0);
    idle(int'(GAP_MAX) + 1);
    idle(3);

    // randomized frames: lengths, gaps, corrupt CRCs, illegal lengths
    for (int f = 0; f < 10; f++) begin
      pl.delete();
      len = $urandom_range(1, 48);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0) begin
        lf = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(SYNC_BUF_DEPTH + 1, 65535);
        pl.delete();
        run_frame(pl, lf, 1'b0, 1'b0, 3, 0, 1'b1);
      end else begin
        run_frame(pl, len, ($urandom_range(0, 3) == 0), 1'b0, 3, 0, 1'b1);
      end
    end

    // reset in the middle of a payload
    drive(HDR0);
    drive(HDR1);
    drive(8'h00);
    drive(8'h0A);
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'h70 + i));
      w.addr = 11'(i);
      w.data = 8'(8'h70 + i);
      exp_wr_q.push_back(w);
    end
    idle(2);
    reset = 1'b0;
    m_ok = 16'd0;
    m_err = 16'd0;
    m_status = SYNC_ST_IDLE;
    idle(2);
    check("midrst_wen", 32'(bus.slink_buf_wen), 0);
    check("midrst_waddr", 32'(bus.slink_buf_waddr), 0);
    check("midrst_wdata", 32'(bus.slink_buf_wdata), 0);
    check("midrst_recv", 32'(bus.sync_recv_en), 0);
    check("midrst_status", 32'(bus.sync_Btoa_en), 0);
    check("midrst_ok_cnt", 32'(bus.frame_ok_cnt), 0);
    check("midrst_err_cnt", 32'(bus.frame_err_cnt), 0);
    reset = 1'b1;
    idle(3);

    // a good frame after reset restarts the counters from zero
    pl = '{8'hDE, 8'hAD};
    run_frame(pl, 2, 1'b0, 1'b0, 0, 0, 1'b1);

    idle(5);
    check("writes_outstanding", exp_wr_q.size(), 0);
    check("events_outstanding", exp_ev_q.size(), 0);
    check("final_ok_cnt", 32'(bus.frame_ok_cnt), 32'(m_ok));
    check("final_err_cnt", 32'(bus.frame_err_cnt), 32'(m_err));
    check("final_status", 32'(bus.sync_Btoa_en), 32'(m_status));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_rx_pack.md
# sync_rx_pack

Receive-side framer for the synchronisation link. It accepts the deserialised byte stream from the serial link, finds frames by header, and writes the payload into the 2048-byte receive buffer, addresses 0..2047. On a good frame it signals the downstream buffer-to-AFPGA transfer stage with `sync_recv_en` and `sync_Btoa_en`. It sits between the link deserialiser and that transfer stage.

## Interface
- `HDR0`, default 8'hEB: first header byte.
- `HDR1`, default 8'h90: second header byte.
- `GAP_MAX`, default 16'd1000: maximum idle clocks between bytes inside a frame.
- `HOLD_CYCLES`, default 12'd2100: clocks for which `sync_recv_en` is held high.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_byte`  in  8  byte from the deserialiser.
- `rx_byte_vld`  in  1  `rx_byte` is valid for this clock.
- `slink_buf_wen`  out  1  buffer write strobe.
- `slink_buf_waddr`  out  11  buffer write address.
- `slink_buf_wdata`  out  8  buffer write data.
- `sync_recv_en`  out  1  frame-ready level to downstream.
- `sync_Btoa_en`  out  2  buffer status: 2'b00 idle or receiving, 2'b10 valid frame, 2'b01 last frame failed.
- `frame_ok_cnt`  out  16  count of good frames; wraps.
- `frame_err_cnt`  out  16  count of failed or dropped frames; wraps.

## Operation
- Frame format: HDR0, HDR1, LEN_H, LEN_L, payload bytes 0..LEN-1, CRC_H, CRC_L.
- LEN is 16-bit big-endian. Legal range is 1..2048.
- CRC is CRC-16/CCITT: polynomial 0x1021, init 0xFFFF, no reflection. It covers LEN_H through the last payload byte.
- States: IDLE, HDR, LEN_H, LEN_L, DATA, CRC_H, CRC_L, CHECK, HOLD.
- IDLE: on a valid byte equal to HDR0, go to HDR.
- HDR:
  - HDR1 → LEN_H.
  - HDR0 → stay in HDR.
  - Any other byte → IDLE. No error is counted.
- LEN_L: when LEN is 0 or greater than 2048, count an error, set status to 01 and go to IDLE. Otherwise go to DATA with the write address at 0.
- DATA:
  - Each valid byte is written to `slink_buf_waddr`, then the address increments.
  - After byte LEN-1, go to CRC_H.
  - Addresses at or above LEN are never written.
- CRC_L → CHECK.
  - CHECK, CRC match: increment `frame_ok_cnt`, set `sync_Btoa_en` to 2'b10, raise `sync_recv_en`, go to HOLD.
  - CHECK, CRC mismatch: increment `frame_err_cnt`, set status to 2'b01, go to IDLE.
- HOLD:
  - `sync_recv_en` stays high for HOLD_CYCLES clocks, then drops; go to IDLE.
  - Bytes arriving during HOLD are discarded, so the buffer is never overwritten while downstream reads it.
  - A HDR0/HDR1 pair seen during HOLD increments `frame_err_cnt` once.
- Status 2'b10 and 2'b01 persist until the next HDR1 is accepted. At that point status returns to 2'b00.
- Gap timeout:
  - Applies in every state from LEN_H through CRC_L.
  - More than GAP_MAX clocks without `rx_byte_vld` aborts the frame: count an error, set status 2'b01, go to IDLE.
  - The gap counter clears on each valid byte.
- Counters saturate at neither end; they wrap 16'hFFFF→0.

## Timing
- Reset values: every output is 0, status is 2'b00, state is IDLE. The same applies when reset is asserted mid-frame: the frame is dropped without an error count.
- Buffer write has a latency of 1 clock: `slink_buf_wen`, address and data are registered on the clock after `rx_byte_vld`.
  - `slink_buf_wen` is high for exactly one clock per payload byte.
  - Consecutive writes back-to-back are supported.
- `sync_recv_en` and status rise 2 clocks after the clock that samples CRC_L (CRC_L → CHECK → outputs registered).
- `sync_recv_en` presents exactly one rising edge per good frame.
- Write-to-ready ordering: the last buffer write is at least 3 clocks before `sync_recv_en` rises.
- `rx_byte_vld` may be high on every clock; there is no backpressure.

## Configuration
- Macro `SYNC_RX_CRC_EN`.
- Defined: the CRC is computed and checked as described.
- Not defined: the CRC bytes are consumed but ignored, every length-legal frame completes as good, and the CRC logic is not synthesised.

## Structure
- Shared package `sync_pkg` holds:
  - the state enum;
  - the status codes `SYNC_ST_IDLE`/`OK`/`ERR`;
  - `SYNC_BUF_DEPTH` = 2048;
  - the CRC polynomial and init constants.
- One sub-module, `crc16_ccitt_byte`: combinational, taking an 8-bit input and 16-bit CRC-in and producing CRC-out. It is instantiated only under `SYNC_RX_CRC_EN`.

## Test plan
- Good frame, LEN=4, payload 11 22 33 44, correct CRC, back-to-back bytes:
  - writes at addresses 0..3 with that data;
  - `sync_recv_en` rises 2 clocks after CRC_L;
  - `sync_Btoa_en`=2'b10; `frame_ok_cnt`=1.
- Same frame with CRC_L flipped: no `sync_recv_en`, status 2'b01, `frame_err_cnt`=1. Without the macro the same stimulus yields status 2'b10.
- LEN=2048 with full payload: the last write is at address 2047 and the frame is good. LEN=2049: error at LEN_L and no writes.
- Stream EB EB 90 00 01 55 + CRC: frame accepted; one write of 0x55 at address 0.
- Second good frame sent during HOLD: no buffer writes, `frame_err_cnt`+1, `sync_recv_en` stays high for the full HOLD_CYCLES.
- Stall GAP_MAX+1 clocks mid-payload: status 2'b01, error counted. Reset mid-frame: all outputs return to 0.
